lcd_responder: RTL and testbench



---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_ddram.sv | 26 ++
 rtl/lcd_responder.sv | 198 +++++++++++++++++++
 tb/tb_lcd_responder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for lcd_responder: FSM states, the blank character and
// instruction-class masks with a decoder that selects the class by highest set bit.
package lcd_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_CLEAR} state_t;

    typedef enum logic [3:0] {
        INS_NOP, INS_CLEAR, INS_HOME, INS_ENTRY, INS_DISP,
        INS_SHIFT, INS_FUNC, INS_CGRAM, INS_DDRAM
    } ins_t;

    localparam logic [7:0] BLANK_CHAR = 8'h20;

    localparam logic [7:0] MASK_DDRAM = 8'h80;
    localparam logic [7:0] MASK_CGRAM = 8'h40;
    localparam logic [7:0] MASK_FUNC  = 8'h20;
    localparam logic [7:0] MASK_SHIFT = 8'h10;
    localparam logic [7:0] MASK_DISP  = 8'h08;
    localparam logic [7:0] MASK_ENTRY = 8'h04;
    localparam logic [7:0] MASK_HOME  = 8'h02;
    localparam logic [7:0] MASK_CLEAR = 8'h01;

    function automatic ins_t ins_decode(input logic [7:0] d);
        if (|(d & MASK_DDRAM)) return INS_DDRAM;
        if (|(d & MASK_CGRAM)) return INS_CGRAM;
        if (|(d & MASK_FUNC))  return INS_FUNC;
        if (|(d & MASK_SHIFT)) return INS_SHIFT;
        if (|(d & MASK_DISP))  return INS_DISP;
        if (|(d & MASK_ENTRY)) return INS_ENTRY;
        if (|(d & MASK_HOME))  return INS_HOME;
        if (|(d & MASK_CLEAR)) return INS_CLEAR;
        return INS_NOP;
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// Display RAM: one synchronous write port, combinational reads at the address
// counter and at the scoreboard side port.
module lcd_ddram #(
    parameter int MEM_DEPTH = 16,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] ac_addr,
    output logic [7:0]        ac_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    assign ac_data = mem[ac_addr];
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_responder.sv
// HD44780-style character-LCD bus responder (peripheral side of E/RS/RW/DATA).
// Define LCD_RESPONDER_BUSY_EN for instruction busy timing; otherwise only the CLEAR fill is busy.
module lcd_responder
    import lcd_pkg::*;
#(
    parameter int MEM_DEPTH = 16,
    parameter int ADDR_W    = $clog2(MEM_DEPTH),
    parameter int BUSY_CYC  = 40,
    parameter int HOME_CYC  = 1600
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              E,
    input  logic              RS,
    input  logic              RW,
    input  logic [7:0]        DATA_IN,
    output logic [7:0]        DATA_OUT,
    output logic              DATA_OE,
    output logic              BUSY,
    output logic [ADDR_W-1:0] AC,
    output logic              DISP_ON,
    output logic              CUR_ON,
    output logic              BLINK,
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic [7:0]        RD_CHAR,
    output logic              ERR
);

`ifdef LCD_RESPONDER_BUSY_EN
    localparam int BUSY_LD = BUSY_CYC;
    localparam int HOME_LD = HOME_CYC;
`else
    localparam int BUSY_LD = 0 * BUSY_CYC;
    localparam int HOME_LD = 0 * HOME_CYC;
`endif
    // Busy time still owed once the fill has consumed MEM_DEPTH cycles of it.
    localparam int CLR_TAIL = (HOME_LD > MEM_DEPTH) ? HOME_LD - MEM_DEPTH : 0;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    function automatic logic [ADDR_W-1:0] ac_step(input logic [ADDR_W-1:0] a, input logic up);
        return up ? a + ADDR_W'(1) : a - ADDR_W'(1);
    endfunction

    // Stage p0: bus capture
    logic       e_p0, rs_p0, rw_p0;
    logic [7:0] d_p0;

    always_ff @(posedge clk) begin
        if (rst) e_p0 <= 1'b0;
        else     e_p0 <= E;
        rs_p0 <= RS;
        rw_p0 <= RW;
        d_p0  <= DATA_IN;
    end

    logic strobe, wr_stb, rd_stb;
    assign strobe = e_p0 & ~E;
    assign wr_stb = strobe & ~rw_p0;
    assign rd_stb = strobe & rw_p0 & rs_p0;

    ins_t ins;
    assign ins = ins_decode(d_p0);

    state_t            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] clr_q, clr_d, ac_q, ac_d;
    logic              id_q, id_d, disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
    logic              err_q, err_d;
    logic              mem_we, ld;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata, ac_char;
    int                ld_cyc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= 32'd0;
            clr_q   <= '0;
            ac_q    <= '0;
            id_q    <= 1'b1;
            disp_q  <= 1'b0;
            cur_q   <= 1'b0;
            blink_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
            ac_q    <= ac_d;
            id_q    <= id_d;
            disp_q  <= disp_d;
            cur_q   <= cur_d;
            blink_q <= blink_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_d     = clr_q;
        ac_d      = ac_q;
        id_d      = id_q;
        disp_d    = disp_q;
        cur_d     = cur_q;
        blink_d   = blink_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_addr  = ac_q;
        mem_wdata = d_p0;
        ld        = 1'b0;
        ld_cyc    = 0;
        case (state_q)
            ST_IDLE: if (wr_stb) begin
                if (rs_p0) begin
                    mem_we = 1'b1;
                    ac_d   = ac_step(ac_q, id_q);
                    ld     = 1'b1;
                    ld_cyc = BUSY_LD;
                end else begin
                    ld     = (ins != INS_NOP) && (ins != INS_CLEAR);
                    ld_cyc = (ins == INS_HOME) ? HOME_LD : BUSY_LD;
                    case (ins)
                        INS_DDRAM: ac_d = d_p0[ADDR_W-1:0];
                        INS_SHIFT: if (!d_p0[3]) ac_d = ac_step(ac_q, d_p0[2]);
                        INS_DISP: begin
                            disp_d  = d_p0[2];
                            cur_d   = d_p0[1];
                            blink_d = d_p0[0];
                        end
                        INS_ENTRY: id_d = d_p0[1];
                        INS_HOME:  ac_d = '0;
                        INS_CLEAR: begin
                            ac_d    = '0;
                            id_d    = 1'b1;
                            clr_d   = '0;
                            state_d = ST_CLEAR;
                        end
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                if (cnt_q == 32'd0) state_d = ST_IDLE;
                else                cnt_d   = cnt_q - 32'd1;
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_q;
                mem_wdata = BLANK_CHAR;
                clr_d     = clr_q + ADDR_W'(1);
                if (clr_q == LAST_ADDR) begin
                    ld     = 1'b1;
                    ld_cyc = CLR_TAIL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (ld) begin
            if (ld_cyc == 0) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_BUSY;
                cnt_d   = 32'(ld_cyc - 1);
            end
        end
        if (wr_stb && state_q != ST_IDLE) err_d = 1'b1;
        // Data reads advance AC even while busy.
        if (rd_stb) ac_d = ac_step(ac_q, id_q);
    end

    lcd_ddram #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) u_ddram (
        .clk     (clk),
        .we      (mem_we),
        .wr_addr (mem_addr),
        .wr_data (mem_wdata),
        .ac_addr (ac_q),
        .ac_data (ac_char),
        .rd_addr (RD_ADDR),
        .rd_data (RD_CHAR)
    );

    logic [6:0] ac7;
    assign ac7     = 7'(ac_q);
    assign BUSY    = (state_q != ST_IDLE);
    assign AC      = ac_q;
    assign DISP_ON = disp_q;
    assign CUR_ON  = cur_q;
    assign BLINK   = blink_q;
    assign ERR     = err_q;
    assign DATA_OE = e_p0 & rw_p0;

    always_comb begin
        DATA_OUT = 8'h00;
        if (DATA_OE) DATA_OUT = rs_p0 ? ac_char : {BUSY, ac7};
    end

endmodule

// File: tb/tb_lcd_responder.sv
// Bench for lcd_responder: directed vector table, hand-written busy/clear/reset
// sequences, and randomized bus traffic checked against a behavioural model.
module tb_lcd_responder;

    localparam int DEPTH = 16;
    localparam int BCYC  = 40;
    localparam int HCYC  = 1600;
`ifdef LCD_RESPONDER_BUSY_EN
    localparam int BUSY_EFF = BCYC;
    localparam int HOME_EFF = HCYC;
`else
    localparam int BUSY_EFF = 0;
    localparam int HOME_EFF = 0;
`endif
    localparam int CLR_TOTAL = (HOME_EFF > DEPTH) ? HOME_EFF : DEPTH;

    logic       clk = 1'b0, rst = 1'b1, E = 1'b0, RS = 1'b0, RW = 1'b0;
    logic [7:0] DATA_IN = 8'h00;
    logic [3:0] RD_ADDR = 4'd0;
    logic [7:0] DATA_OUT, RD_CHAR;
    logic       DATA_OE, BUSY, DISP_ON, CUR_ON, BLINK, ERR;
    logic [3:0] AC;

    lcd_responder #(.MEM_DEPTH(DEPTH), .BUSY_CYC(BCYC), .HOME_CYC(HCYC)) dut (
        .clk(clk), .rst(rst), .E(E), .RS(RS), .RW(RW), .DATA_IN(DATA_IN),
        .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .BUSY(BUSY), .AC(AC),
        .DISP_ON(DISP_ON), .CUR_ON(CUR_ON), .BLINK(BLINK),
        .RD_ADDR(RD_ADDR), .RD_CHAR(RD_CHAR), .ERR(ERR)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;

    // Behavioural model state
    logic [7:0] m_mem [DEPTH];
    int         m_ac, busy_until, fill_end;
    bit         m_id, m_err, mon_en;
    bit   [2:0] m_flags;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic int step(input int a, input bit up);
        return (a + (up ? 1 : DEPTH - 1)) % DEPTH;
    endfunction

    function automatic void blank_all();
        for (int a = 0; a < DEPTH; a++) m_mem[a] = 8'h20;
    endfunction

    function automatic void model_reset(input int r);
        m_ac = 0; m_id = 1; m_flags = 3'b000; m_err = 0;
        blank_all();
        busy_until = r + CLR_TOTAL;
        fill_end   = r + DEPTH;
    endfunction

    // Effect of one strobe at clock edge s, from the instruction table.
    function automatic void model_strobe(input bit rs, input bit rw, input logic [7:0] d, input int s);
        if (rw) begin
            if (rs) m_ac = step(m_ac, m_id);
        end else if (s - 1 < busy_until) begin
            m_err = 1;
        end else if (rs) begin
            m_mem[m_ac] = d; m_ac = step(m_ac, m_id); busy_until = s + BUSY_EFF;
        end else if (d >= 8'd128) begin
            m_ac = int'(d) % DEPTH; busy_until = s + BUSY_EFF;
        end else if (d >= 8'd32) begin
            busy_until = s + BUSY_EFF;
        end else if (d >= 8'd16) begin
            if (d[3] == 1'b0) m_ac = step(m_ac, d[2]);
            busy_until = s + BUSY_EFF;
        end else if (d >= 8'd8) begin
            m_flags = d[2:0]; busy_until = s + BUSY_EFF;
        end else if (d >= 8'd4) begin
            m_id = d[1]; busy_until = s + BUSY_EFF;
        end else if (d >= 8'd2) begin
            m_ac = 0; busy_until = s + HOME_EFF;
        end else if (d == 8'd1) begin
            m_ac = 0; m_id = 1; blank_all();
            busy_until = s + CLR_TOTAL; fill_end = s + DEPTH;
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("busy", BUSY, cyc < busy_until);
            check("ac", AC, m_ac);
            check("err", ERR, m_err);
            check("flags", {DISP_ON, CUR_ON, BLINK}, m_flags);
        end
    end

    task automatic bus_cycle(input bit rs, input bit rw, input logic [7:0] d);
        logic [7:0] want;
        @(posedge clk); #1;
        RS = rs; RW = rw; DATA_IN = d; E = 1'b1;
        @(posedge clk); #1;
        if (rw) begin
            if (rs) want = m_mem[m_ac];
            else    want = {cyc < busy_until, 7'(m_ac)};
            check("read_oe", DATA_OE, 1'b1);
            check(rs ? "data_read" : "busy_read", DATA_OUT, want);
        end
        E = 1'b0;
        @(posedge clk); #1;
        model_strobe(rs, rw, d, cyc);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (BUSY && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_idle", BUSY, 1'b0);
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk); #1;
        rst = 1'b1; E = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset(cyc);
    endtask

    task automatic check_busy_len(input string name);
        int n;
        n = 0;
        while (BUSY && n < 5000) begin
            n++;
            @(posedge clk); #1;
        end
        check(name, n, CLR_TOTAL);
    endtask

    task automatic check_ram(input string name, input bit vs_blank);
        for (int a = 0; a < DEPTH; a++) begin
            RD_ADDR = 4'(a);
            #1;
            check($sformatf("%s[%0d]", name, a), RD_CHAR, vs_blank ? 8'h20 : m_mem[a]);
        end
    endtask

    typedef struct {
        bit         rs;
        bit         rw;
        logic [7:0] d;
        logic [3:0] addr;
        logic [7:0] ch;
        logic [3:0] ac;
        logic [2:0] flags;
    } vec_t;

    vec_t vt[20];

    bit         r_rs, r_rw;
    logic [7:0] r_d;

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{0, 0, 8'h83, 4'd3,  8'h20, 4'd3,  3'd0};
        vt[1]  = '{1, 0, 8'h41, 4'd3,  8'h41, 4'd4,  3'd0};
        vt[2]  = '{1, 0, 8'h42, 4'd4,  8'h42, 4'd5,  3'd0};
        vt[3]  = '{0, 0, 8'h0F, 4'd4,  8'h42, 4'd5,  3'd7};
        vt[4]  = '{0, 0, 8'h80, 4'd0,  8'h20, 4'd0,  3'd7};
        vt[5]  = '{0, 0, 8'h04, 4'd0,  8'h20, 4'd0,  3'd7};
        vt[6]  = '{1, 0, 8'h5A, 4'd0,  8'h5A, 4'd15, 3'd7};
        vt[7]  = '{0, 0, 8'h06, 4'd15, 8'h20, 4'd15, 3'd7};
        vt[8]  = '{1, 0, 8'h51, 4'd15, 8'h51, 4'd0,  3'd7};
        vt[9]  = '{0, 0, 8'h14, 4'd0,  8'h5A, 4'd1,  3'd7};
        vt[10] = '{0, 0, 8'h10, 4'd3,  8'h41, 4'd0,  3'd7};
        vt[11] = '{0, 0, 8'h10, 4'd4,  8'h42, 4'd15, 3'd7};
        vt[12] = '{0, 0, 8'h18, 4'd15, 8'h51, 4'd15, 3'd7};
        vt[13] = '{1, 1, 8'h00, 4'd15, 8'h51, 4'd0,  3'd7};
        vt[14] = '{0, 0, 8'h08, 4'd0,  8'h5A, 4'd0,  3'd0};
        vt[15] = '{0, 0, 8'h8A, 4'd10, 8'h20, 4'd10, 3'd0};
        vt[16] = '{0, 0, 8'h02, 4'd3,  8'h41, 4'd0,  3'd0};
        vt[17] = '{0, 0, 8'h40, 4'd3,  8'h41, 4'd0,  3'd0};
        vt[18] = '{0, 0, 8'h3F, 4'd4,  8'h42, 4'd0,  3'd0};
        vt[19] = '{0, 0, 8'h00, 4'd0,  8'h5A, 4'd0,  3'd0};

        // Reset state and the automatic fill
        do_reset(3);
        mon_en = 1;
        check("rst_busy", BUSY, 1'b1);
        check("rst_ac", AC, 4'd0);
        check("rst_err", ERR, 1'b0);
        check("rst_oe", DATA_OE, 1'b0);
        check("rst_dout", DATA_OUT, 8'h00);
        check("rst_flags", {DISP_ON, CUR_ON, BLINK}, 3'b000);
        check_busy_len("rst_busy_len");
        check_ram("rst_ram", 1);

        // Directed vector table
        for (int i = 0; i < 20; i++) begin
            wait_idle();
            bus_cycle(vt[i].rs, vt[i].rw, vt[i].d);
            RD_ADDR = vt[i].addr;
            #1;
            check($sformatf("vec%0d_char", i), RD_CHAR, vt[i].ch);
            check($sformatf("vec%0d_ac", i), AC, vt[i].ac);
            check($sformatf("vec%0d_flags", i), {DISP_ON, CUR_ON, BLINK}, vt[i].flags);
        end

        // Data write strobed ~10 cycles after a previous write
        wait_idle();
        bus_cycle(0, 0, 8'h85);
        wait_idle();
        bus_cycle(1, 0, 8'h61);
        repeat (7) @(posedge clk);
        bus_cycle(1, 0, 8'h77);
        RD_ADDR = 4'd6;
        #1;
        check("collide_char", RD_CHAR, m_mem[6]);
        check("collide_err", ERR, m_err);

        // Busy read straight after display-control write, then again when idle
        wait_idle();
        bus_cycle(0, 0, 8'h0F);
        bus_cycle(0, 1, 8'h00);
        check("dctl_flags", {DISP_ON, CUR_ON, BLINK}, 3'b111);
        wait_idle();
        bus_cycle(0, 1, 8'h00);

        // Clear after filling the RAM
        for (int a = 0; a < DEPTH; a++) begin
            wait_idle();
            bus_cycle(1, 0, 8'(8'h30 + a));
        end
        wait_idle();
        bus_cycle(0, 0, 8'h01);
        check("clr_ac", AC, 4'd0);
        check_busy_len("clr_busy_len");
        check_ram("clr_ram", 1);

        // Write during the post-reset fill, then reset in the middle of a write
        do_reset(2);
        bus_cycle(1, 0, 8'h33);
        check("fill_err", ERR, 1'b1);
        wait_idle();
        check_ram("fill_ram", 1);
        bus_cycle(1, 0, 8'h44);
        repeat (5) @(posedge clk);
        do_reset(2);
        check("rst2_err", ERR, 1'b0);
        check("rst2_ac", AC, 4'd0);
        check_busy_len("rst2_busy_len");
        check_ram("rst2_ram", 1);

        // Randomized traffic against the model
        for (int i = 0; i < 150; i++) begin
            r_rs = 1'($urandom % 2);
            r_rw = (($urandom % 4) == 0);
            r_d  = 8'($urandom % 256);
            if (!r_rs && !r_rw && r_d >= 8'd1 && r_d <= 8'd3 && ($urandom % 4) != 0) r_d = 8'h0C;
            if (cyc < fill_end || ($urandom % 6) != 0) wait_idle();
            bus_cycle(r_rs, r_rw, r_d);
        end
        wait_idle();
        check_ram("rand_ram", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
